// File: rtl/alien_pixel_painter_if.sv
// Request/response bundle between the alien control FSM, the pixel painter
// and the VGA adapter. The controller side is the master; the painter is the slave.
interface alien_pixel_painter_if;
   logic       kill1, kill2, kill3, kill4, kill5;
   logic       moveDown;
   logic [7:0] alienTopX, alienBottomX;
   logic [6:0] alienTopY, alienBottomY;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       cleared1, cleared2, cleared3, cleared4, cleared5;
   logic       clearedShift;
   logic       busy;

   modport master (
      output kill1, kill2, kill3, kill4, kill5, moveDown,
             alienTopX, alienTopY, alienBottomX, alienBottomY,
      input  x, y, colour, plot,
             cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
   );

   modport slave (
      input  kill1, kill2, kill3, kill4, kill5, moveDown,
             alienTopX, alienTopY, alienBottomX, alienBottomY,
      output x, y, colour, plot,
             cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
   );
endinterface

// File: rtl/alien_pixel_painter.sv
// Alien row painter: turns kill/moveDown pulses into one-pixel-per-clock VGA
// writes (initial row paint, rectangle erase, one-pixel row shift) and
// acknowledges each job with a single-cycle cleared pulse.
module alien_pixel_painter #(
   parameter logic [7:0] WIDTH     = 8'd12,
   parameter logic [6:0] HEIGHT    = 7'd10,
   parameter logic [7:0] GAP       = 8'd20,
   parameter logic [7:0] START_X   = 8'd10,
   parameter logic [6:0] START_Y   = 7'd10,
   parameter logic [2:0] ALIEN_COL = 3'b010,
   parameter logic [2:0] BG_COL    = 3'b000,
   parameter logic [6:0] Y_MAX     = 7'd119
) (
   input logic                  clk,
   input logic                  reset,
   alien_pixel_painter_if.slave bus
);
   typedef enum logic [2:0] {INIT_DRAW, IDLE, ERASE, SHIFT_ERASE, SHIFT_DRAW, DONE} state_t;

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] tx;
      logic [6:0] ty;
      logic [7:0] bx;
      logic [6:0] by;
   } kill_t;

   state_t     state, state_d;
   logic [7:0] cx, cx_d, xs, xs_d, xe, xe_d;
   logic [6:0] cy, cy_d, ye, ye_d, row_y, row_y_d;
   logic [2:0] colour, colour_d, ai, ai_d;
   logic [4:0] alive, alive_d, kvec;
   logic [5:0] done_sel, done_sel_d;
   logic       init_pend, init_pend_d, pk_v, pk_v_d, pd, pd_d;
   kill_t      pk, pk_d, new_k, sel_k;
   logic       new_v, plot, raster, line_done, start_kill, step_alien;
   logic [3:0] from_idx, nxt;
   logic [7:0] draw_y8, row_inc8;
   logic       draw_ok;

   function automatic logic [7:0] left_x(input logic [2:0] i);
      return START_X + 8'(i) * (WIDTH + GAP);
   endfunction

   // {found, index} of the first alive alien at or above 'from'
   function automatic logic [3:0] find_alive(input logic [4:0] a, input logic [3:0] from);
      logic [3:0] r;
      r = '0;
      for (int unsigned i = 0; i < 5; i++)
         if (!r[3] && i >= 32'(from) && a[i]) r = {1'b1, 3'(i)};
      return r;
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         init_pend <= 1'b1;
         cx        <= '0;
         cy        <= '0;
         xs        <= '0;
         xe        <= '0;
         ye        <= '0;
         colour    <= BG_COL;
         ai        <= '0;
         alive     <= '1;
         row_y     <= START_Y;
         done_sel  <= '0;
         pk_v      <= 1'b0;
         pk        <= '0;
         pd        <= 1'b0;
      end else begin
         state     <= state_d;
         init_pend <= init_pend_d;
         cx        <= cx_d;
         cy        <= cy_d;
         xs        <= xs_d;
         xe        <= xe_d;
         ye        <= ye_d;
         colour    <= colour_d;
         ai        <= ai_d;
         alive     <= alive_d;
         row_y     <= row_y_d;
         done_sel  <= done_sel_d;
         pk_v      <= pk_v_d;
         pk        <= pk_d;
         pd        <= pd_d;
      end
   end

   // Next-state, raster stepping, request capture and job dispatch
   always_comb begin
      state_d     = state;
      init_pend_d = init_pend;
      cx_d        = cx;
      cy_d        = cy;
      xs_d        = xs;
      xe_d        = xe;
      ye_d        = ye;
      colour_d    = colour;
      ai_d        = ai;
      alive_d     = alive;
      row_y_d     = row_y;
      done_sel_d  = done_sel;
      pk_v_d      = pk_v;
      pk_d        = pk;
      pd_d        = pd;
      start_kill  = 1'b0;
      step_alien  = 1'b0;
      sel_k       = pk;

      kvec  = {bus.kill5, bus.kill4, bus.kill3, bus.kill2, bus.kill1};
      new_v = |kvec;
      new_k = {3'd0, bus.alienTopX, bus.alienTopY, bus.alienBottomX, bus.alienBottomY};
      for (int unsigned i = 5; i > 0; i--)
         if (kvec[i-1]) new_k.idx = 3'(i-1);

      draw_y8  = {1'b0, row_y} + {1'b0, HEIGHT} + 8'd1;
      draw_ok  = draw_y8 <= {1'b0, Y_MAX};
      row_inc8 = {1'b0, row_y} + 8'd1;
      from_idx = (state == IDLE) ? 4'd0 : {1'b0, ai} + 4'd1;
      nxt      = find_alive(alive, from_idx);

      // Requests arriving while occupied wait in the single-entry slots
      if (new_v && !pk_v) begin
         pk_v_d = 1'b1;
         pk_d   = new_k;
      end
      if (bus.moveDown) pd_d = 1'b1;

      raster = state inside {INIT_DRAW, ERASE, SHIFT_ERASE, SHIFT_DRAW};
      plot   = raster;
      if (raster) begin
         if (cx != xe) cx_d = cx + 8'd1;
         else if (cy != ye) begin
            cx_d = xs;
            cy_d = cy + 7'd1;
         end
      end
      line_done = raster && (cx == xe) && (cy == ye);

      case (state)
         IDLE: begin
            if (init_pend) begin
               init_pend_d = 1'b0;
               state_d     = INIT_DRAW;
               ai_d        = '0;
               cx_d        = left_x(3'd0);
               xs_d        = left_x(3'd0);
               xe_d        = left_x(3'd0) + WIDTH;
               cy_d        = row_y;
               ye_d        = row_y + HEIGHT;
               colour_d    = ALIEN_COL;
            end else if (pk_v || new_v) begin
               // A served pending kill frees its slot for this cycle's request
               start_kill = 1'b1;
               sel_k      = pk_v ? pk : new_k;
               pk_v_d     = pk_v && new_v;
               pk_d       = new_k;
            end else if (pd || bus.moveDown) begin
               pd_d       = pd && bus.moveDown;
               done_sel_d = 6'b100000;
               step_alien = 1'b1;
            end
         end
         INIT_DRAW: if (line_done) begin
            if (ai == 3'd4) state_d = IDLE;
            else begin
               ai_d = ai + 3'd1;
               cx_d = left_x(ai + 3'd1);
               xs_d = left_x(ai + 3'd1);
               xe_d = left_x(ai + 3'd1) + WIDTH;
               cy_d = row_y;
               ye_d = row_y + HEIGHT;
            end
         end
         ERASE: if (line_done) state_d = DONE;
         SHIFT_ERASE: if (line_done) begin
            if (draw_ok) begin
               state_d  = SHIFT_DRAW;
               cx_d     = xs;
               cy_d     = draw_y8[6:0];
               ye_d     = draw_y8[6:0];
               colour_d = ALIEN_COL;
            end else step_alien = 1'b1;
         end
         SHIFT_DRAW: if (line_done) step_alien = 1'b1;
         DONE: begin
            state_d = IDLE;
            if (done_sel[5] && row_inc8 <= {1'b0, Y_MAX - HEIGHT}) row_y_d = row_inc8[6:0];
         end
         default: state_d = IDLE;
      endcase

      if (start_kill) begin
         alive_d[sel_k.idx] = 1'b0;
         done_sel_d         = 6'd1 << sel_k.idx;
         if (sel_k.bx < sel_k.tx || sel_k.by < sel_k.ty) state_d = DONE;
         else begin
            state_d  = ERASE;
            cx_d     = sel_k.tx;
            cy_d     = sel_k.ty;
            xs_d     = sel_k.tx;
            xe_d     = sel_k.bx;
            ye_d     = sel_k.by;
            colour_d = BG_COL;
         end
      end

      if (step_alien) begin
         if (nxt[3]) begin
            state_d  = SHIFT_ERASE;
            ai_d     = nxt[2:0];
            cx_d     = left_x(nxt[2:0]);
            xs_d     = left_x(nxt[2:0]);
            xe_d     = left_x(nxt[2:0]) + WIDTH;
            cy_d     = row_y;
            ye_d     = row_y;
            colour_d = BG_COL;
         end else state_d = DONE;
      end
   end

   assign bus.x            = cx;
   assign bus.y            = cy;
   assign bus.colour       = colour;
   assign bus.plot         = plot;
   assign bus.cleared1     = (state == DONE) && done_sel[0];
   assign bus.cleared2     = (state == DONE) && done_sel[1];
   assign bus.cleared3     = (state == DONE) && done_sel[2];
   assign bus.cleared4     = (state == DONE) && done_sel[3];
   assign bus.cleared5     = (state == DONE) && done_sel[4];
   assign bus.clearedShift = (state == DONE) && done_sel[5];
   assign bus.busy         = (state != IDLE) || init_pend || pk_v || pd;
endmodule

// File: tb/tb_alien_pixel_painter.sv
// Scoreboard bench for alien_pixel_painter: stimulus pushes the expected pixel
// and done-pulse sequence, a negedge monitor pops and compares.
module tb_alien_pixel_painter;
   typedef struct {
      bit         is_done;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [5:0] done;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   plot_count = 0;
   int   clr_cyc = -1;
   int   req_cyc = 0;
   int   p0;
   int   row;
   ev_t  exp_q[$];
   ev_t  mon_e;
   logic [5:0] mon_clr;
   int   lefts[5] = '{10, 42, 74, 106, 138};

   alien_pixel_painter_if bus();

   alien_pixel_painter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every plot and every done pulse must match the scoreboard head
   always @(negedge clk) begin
      mon_clr = {bus.clearedShift, bus.cleared5, bus.cleared4, bus.cleared3, bus.cleared2, bus.cleared1};
      if (bus.plot) begin
         plot_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pix_extra got x=%0d y=%0d c=%0d want nothing", bus.x, bus.y, bus.colour);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_done || mon_e.x !== bus.x || mon_e.y !== bus.y || mon_e.c !== bus.colour) begin
               errors++;
               $display("FAIL pix got x=%0d y=%0d c=%0d want done=%0d x=%0d y=%0d c=%0d",
                        bus.x, bus.y, bus.colour, mon_e.is_done, mon_e.x, mon_e.y, mon_e.c);
            end
         end
      end
      if (mon_clr != 6'd0) begin
         clr_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_extra got cleared=%b want nothing", mon_clr);
         end else begin
            mon_e = exp_q.pop_front();
            if (!mon_e.is_done || mon_e.done !== mon_clr) begin
               errors++;
               $display("FAIL done got cleared=%b want done=%0d cleared=%b", mon_clr, mon_e.is_done, mon_e.done);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic push_box(input int x0, input int y0, input int x1, input int y1, input int c);
      ev_t e;
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++) begin
            e.is_done = 1'b0;
            e.x = 8'(xx);
            e.y = 7'(yy);
            e.c = 3'(c);
            e.done = '0;
            exp_q.push_back(e);
         end
   endtask

   task automatic push_done(input logic [5:0] m);
      ev_t e;
      e.is_done = 1'b1;
      e.x = '0;
      e.y = '0;
      e.c = '0;
      e.done = m;
      exp_q.push_back(e);
   endtask

   task automatic push_init(input int r);
      for (int i = 0; i < 5; i++) push_box(lefts[i], r, lefts[i] + 12, r + 10, 2);
   endtask

   task automatic push_shift(input logic [4:0] al, input int r);
      for (int i = 0; i < 5; i++)
         if (al[i]) begin
            push_box(lefts[i], r, lefts[i] + 12, r, 0);
            if (r + 11 <= 119) push_box(lefts[i], r + 11, lefts[i] + 12, r + 11, 2);
         end
      push_done(6'b100000);
   endtask

   // Drive one request cycle; caller is positioned at a negedge
   task automatic issue(input logic [5:0] req, input int tx, input int ty, input int bx, input int by);
      {bus.moveDown, bus.kill5, bus.kill4, bus.kill3, bus.kill2, bus.kill1} = req;
      bus.alienTopX    = 8'(tx);
      bus.alienTopY    = 7'(ty);
      bus.alienBottomX = 8'(bx);
      bus.alienBottomY = 7'(by);
      req_cyc = cyc;
      @(negedge clk);
      {bus.moveDown, bus.kill5, bus.kill4, bus.kill3, bus.kill2, bus.kill1} = '0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            checks++;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy=1 want busy=0 within %0d cycles", name, maxc);
   endtask

   initial begin
      reset = 1'b0;
      {bus.moveDown, bus.kill5, bus.kill4, bus.kill3, bus.kill2, bus.kill1} = '0;
      bus.alienTopX = '0;
      bus.alienTopY = '0;
      bus.alienBottomX = '0;
      bus.alienBottomY = '0;
      repeat (3) @(negedge clk);
      check("rst_plot", int'(bus.plot), 0);
      check("rst_x", int'(bus.x), 0);
      check("rst_y", int'(bus.y), 0);
      check("rst_colour", int'(bus.colour), 0);
      check("rst_cleared", int'({bus.clearedShift, bus.cleared5, bus.cleared4,
                                 bus.cleared3, bus.cleared2, bus.cleared1}), 0);

      // Initial paint of the full row
      push_init(10);
      p0 = plot_count;
      reset = 1'b1;
      wait_idle("init", 1000);
      check("init_plots", plot_count - p0, 715);
      check("init_hold_x", int'(bus.x), 150);
      check("init_hold_y", int'(bus.y), 20);
      check("init_q", exp_q.size(), 0);

      // kill1: 13x11 erase, cleared1 at cycle 144
      push_box(10, 10, 22, 20, 0);
      push_done(6'b000001);
      p0 = plot_count;
      issue(6'b000001, 10, 10, 22, 20);
      wait_idle("kill1", 400);
      check("kill1_plots", plot_count - p0, 143);
      check("kill1_latency", clr_cyc - req_cyc, 144);
      check("kill1_q", exp_q.size(), 0);

      // moveDown with aliens 1..4 alive
      push_shift(5'b11110, 10);
      p0 = plot_count;
      issue(6'b100000, 0, 0, 0, 0);
      wait_idle("shift1", 400);
      check("shift1_plots", plot_count - p0, 104);
      check("shift1_q", exp_q.size(), 0);

      // kill3 one cycle into a shift: held pending, served after the shift
      push_shift(5'b11110, 11);
      push_box(74, 12, 86, 22, 0);
      push_done(6'b000100);
      p0 = plot_count;
      issue(6'b100000, 0, 0, 0, 0);
      issue(6'b000100, 74, 12, 86, 22);
      wait_idle("shift_kill3", 600);
      check("shift_kill3_plots", plot_count - p0, 247);
      check("shift_kill3_q", exp_q.size(), 0);

      // kill2 + moveDown together: erase first, then shift skips dead aliens
      push_box(42, 12, 54, 22, 0);
      push_done(6'b000010);
      push_shift(5'b11000, 12);
      p0 = plot_count;
      issue(6'b100010, 42, 12, 54, 22);
      wait_idle("kill2_shift", 600);
      check("kill2_shift_plots", plot_count - p0, 195);
      check("kill2_shift_q", exp_q.size(), 0);

      // Degenerate box on an already-dead alien: no plots, cleared1 next cycle
      push_done(6'b000001);
      p0 = plot_count;
      issue(6'b000001, 20, 12, 10, 22);
      wait_idle("degen", 50);
      check("degen_plots", plot_count - p0, 0);
      check("degen_latency", clr_cyc - req_cyc, 1);

      // kill4 + kill5 together: only kill4 served
      push_box(106, 13, 107, 14, 0);
      push_done(6'b001000);
      p0 = plot_count;
      issue(6'b011000, 106, 13, 107, 14);
      wait_idle("multi", 50);
      repeat (5) @(negedge clk);
      check("multi_plots", plot_count - p0, 4);
      check("multi_q", exp_q.size(), 0);

      // Walk the remaining alien down to the bottom guard
      row = 13;
      while (row < 109) begin
         push_shift(5'b10000, row);
         issue(6'b100000, 0, 0, 0, 0);
         wait_idle("walk", 100);
         row++;
      end
      check("walk_q", exp_q.size(), 0);
      for (int k = 0; k < 2; k++) begin
         push_shift(5'b10000, 109);
         p0 = plot_count;
         issue(6'b100000, 0, 0, 0, 0);
         wait_idle("guard", 100);
         check("guard_plots", plot_count - p0, 13);
         check("guard_q", exp_q.size(), 0);
      end

      // Reset in the middle of an erase
      push_box(138, 100, 150, 119, 0);
      push_done(6'b010000);
      issue(6'b010000, 138, 100, 150, 119);
      repeat (19) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_plot", int'(bus.plot), 0);
      check("midrst_x", int'(bus.x), 0);
      check("midrst_y", int'(bus.y), 0);
      exp_q.delete();
      push_init(10);
      @(negedge clk);
      check("midrst_held_plot", int'(bus.plot), 0);
      p0 = plot_count;
      reset = 1'b1;
      wait_idle("reinit", 1000);
      check("reinit_plots", plot_count - p0, 715);
      check("reinit_hold_x", int'(bus.x), 150);
      check("reinit_q", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
